arbitro_mux_memoria: RTL
========================

ARBITRO_MUX_MEMORIA -- requirements
Module: arbitro_mux_memoria

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum number of consecutive transfers granted to one requester while the other is waiting; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_L, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have ports valid0 / valid1, input, 1 bit each: requester 0/1 presents data.
REQ-005 SHALL have ports data_in0 / data_in1, input, 2 bits each: requester 0/1 payload.
REQ-006 SHALL have ports ready0 / ready1, output, 1 bit each: requester 0/1 transfer accepted this cycle when high together with its valid.
REQ-007 SHALL have port selector, output, 1 bit: current grant (0 = requester 0, 1 = requester 1), drives the memory mux select.
REQ-008 SHALL have port data_out, output, 2 bits: registered payload of the last accepted transfer.
REQ-009 SHALL have port valid_out, output, 1 bit: data_out holds an undelivered word.
REQ-010 SHALL have port ready_out, input, 1 bit: downstream accepts data_out when high together with valid_out.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT0, GRANT1; selector = 1 only in GRANT1.
REQ-012 SHALL drive ready_i = (state == GRANTi) && (!valid_out || ready_out); never both ready0 and ready1 high.
REQ-013 On a transfer (valid_i && ready_i), data_out SHALL load data_in_i and valid_out SHALL be 1 on the next cycle (one-cycle latency).
REQ-014 With valid_out && !ready_out, data_out and valid_out SHALL hold unchanged.
REQ-015 With valid_out && ready_out and no transfer, valid_out SHALL clear next cycle; data_out holds its value.
REQ-016 From IDLE: only valid0 -> GRANT0; only valid1 -> GRANT1; both -> the requester not equal to last_served; neither -> stay.
REQ-017 In GRANTi, burst_cnt SHALL increment per transfer from requester i and clear on every state change.
REQ-018 In GRANTi, if the transfer this cycle makes burst_cnt reach MAX_BURST and valid of the other requester is high, SHALL move to GRANT(other).
REQ-019 In GRANTi, if burst_cnt reaches MAX_BURST and the other requester is idle, SHALL stay in GRANTi and clear burst_cnt.
REQ-020 In GRANTi with valid_i low, SHALL move to GRANT(other) if the other valid is high, else to IDLE.
REQ-021 In GRANTi with valid_i high but stalled by ready_out low, SHALL stay and not increment burst_cnt.
REQ-022 last_served SHALL update to i whenever leaving GRANTi.
REQ-023 Request-to-output latency from IDLE: valid at cycle t -> grant at t+1 -> valid_out at t+2.

Reset
REQ-024 With reset_L low at a rising edge: state = IDLE, selector = 0, valid_out = 0, data_out = 2'b00, burst_cnt = 0, last_served = 1 (requester 0 wins first tie).
REQ-025 Reset mid-transfer SHALL discard any held data_out word; no transfer occurs in a reset cycle (ready0 = ready1 = 0 while reset_L low).

Structure
REQ-026 SHALL place state encoding (IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10) and the default MAX_BURST in a shared package.
REQ-027 SHALL contain one sub-module, registro_salida: the data_out/valid_out output register with hold logic.
REQ-028 SHALL be synthesizable by Yosys with the team cell library, with no latches.

Verification
REQ-029 Reset: reset_L=0 two cycles with valid0=valid1=1 -> selector=0, valid_out=0, data_out=00, ready0=ready1=0.
REQ-030 Single requester: valid0=1, data_in0=2'b10 from cycle t, ready_out=1 -> GRANT0 at t+1, data_out=10, valid_out=1 at t+2.
REQ-031 Contention, MAX_BURST=4: valid0=valid1=1 continuously, ready_out=1 -> four words from requester 0, then selector=1 and four words from requester 1, alternating.
REQ-032 Backpressure: ready_out=0 for 3 cycles after first word 2'b01 -> data_out held at 01, ready0=0, burst_cnt unchanged; resumes when ready_out=1.
REQ-033 Early release: in GRANT1 valid1 drops after 2 words with valid0=1 -> next cycle selector=0, last_served=1.
REQ-034 Mid-burst reset: assert reset_L=0 during GRANT1 with valid_out=1 -> next cycle IDLE, valid_out=0; after release with both valid, requester 0 granted first.

Source files
------------

// File: rtl/arbitro_mux_memoria_pkg.sv
// Shared definitions for the two-requester memory mux arbiter:
// FSM state encoding, default burst length and a grant helper.
package arbitro_mux_memoria_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  localparam int MAX_BURST_DEFAULT = 4;

  // Grant state that serves requester r.
  function automatic state_t grant_of(input logic r);
    return r ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/arbitro_mux_memoria_registro_salida.sv
// Output register: captures an accepted word and holds it until the
// downstream side takes it; a new load always wins over a drain.
module registro_salida (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       load,
  input  logic [1:0] data_in,
  input  logic       ready_out,
  output logic [1:0] data_out,
  output logic       valid_out
);

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      data_out  <= 2'b00;
      valid_out <= 1'b0;
    end else if (load) begin
      data_out  <= data_in;
      valid_out <= 1'b1;
    end else if (valid_out && ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/arbitro_mux_memoria.sv
// Two-requester round-robin arbiter with bounded bursts feeding a single
// registered output word toward memory.
module arbitro_mux_memoria
  import arbitro_mux_memoria_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       valid0,
  input  logic       valid1,
  input  logic [1:0] data_in0,
  input  logic [1:0] data_in1,
  output logic       ready0,
  output logic       ready1,
  output logic       selector,
  output logic [1:0] data_out,
  output logic       valid_out,
  input  logic       ready_out
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t     state, state_next;
  logic [3:0] burst_cnt, burst_cnt_next;
  logic       last_served, last_served_next;
  logic       out_free;
  logic       xfer0, xfer1;
  logic [1:0] data_sel;

  // Readies are gated by reset so no word is accepted in a reset cycle.
  assign out_free = !valid_out || ready_out;
  assign ready0   = reset_L && (state == GRANT0) && out_free;
  assign ready1   = reset_L && (state == GRANT1) && out_free;
  assign xfer0    = valid0 && ready0;
  assign xfer1    = valid1 && ready1;
  assign selector = (state == GRANT1);
  assign data_sel = selector ? data_in1 : data_in0;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state       <= IDLE;
      burst_cnt   <= 4'd0;
      last_served <= 1'b1;
    end else begin
      state       <= state_next;
      burst_cnt   <= burst_cnt_next;
      last_served <= last_served_next;
    end
  end

  always_comb begin
    state_next       = state;
    burst_cnt_next   = burst_cnt;
    last_served_next = last_served;
    case (state)
      IDLE: begin
        burst_cnt_next = 4'd0;
        if (valid0 && valid1)
          state_next = grant_of(!last_served);
        else if (valid0)
          state_next = GRANT0;
        else if (valid1)
          state_next = GRANT1;
      end
      GRANT0: begin
        if (!valid0) begin
          burst_cnt_next   = 4'd0;
          last_served_next = 1'b0;
          state_next       = valid1 ? GRANT1 : IDLE;
        end else if (xfer0) begin
          if (burst_cnt == BURST_LAST) begin
            burst_cnt_next = 4'd0;
            if (valid1) begin
              state_next       = GRANT1;
              last_served_next = 1'b0;
            end
          end else begin
            burst_cnt_next = burst_cnt + 4'd1;
          end
        end
      end
      GRANT1: begin
        if (!valid1) begin
          burst_cnt_next   = 4'd0;
          last_served_next = 1'b1;
          state_next       = valid0 ? GRANT0 : IDLE;
        end else if (xfer1) begin
          if (burst_cnt == BURST_LAST) begin
            burst_cnt_next = 4'd0;
            if (valid0) begin
              state_next       = GRANT0;
              last_served_next = 1'b1;
            end
          end else begin
            burst_cnt_next = burst_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_next     = IDLE;
        burst_cnt_next = 4'd0;
      end
    endcase
  end

  registro_salida u_registro_salida (
    .clk       (clk),
    .reset_L   (reset_L),
    .load      (xfer0 || xfer1),
    .data_in   (data_sel),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

endmodule
